// File: rtl/nibble_collector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_pkg
//  Purpose  : Shared lane/word types and constants for the nibble collector
//             and the downstream 4-lane sorter stage.
//  Contents : LANE_W, LANES, lane_t, word_t, PAD_LANE, LEN_W, state_t
//  Revision : 1.0 - initial release
// ============================================================================
package nibble_pkg;

  localparam int LANE_W = 4;
  localparam int LANES  = 4;
  localparam int LEN_W  = $clog2(LANES + 1);

  typedef logic [LANE_W-1:0]       lane_t;
  typedef logic [LANES*LANE_W-1:0] word_t;

  // Padding sorts to the top lanes because it is the largest lane value.
  localparam lane_t PAD_LANE = '1;

  typedef enum logic [0:0] {
    FILL = 1'b0,   // collecting nibbles into acc
    HOLD = 1'b1    // acc holds a finished word waiting for the out register
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nibble_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_collector_if
//  Purpose  : Nibble input stream plus packed-word output stream.
//  Signals  : in_valid/in_ready/in_data/in_last   - nibble stream
//             out_valid/out_ready/out_data/out_len - packed word stream
//  Modports : slave  - the collector
//             master - the environment feeding/draining it
//  Revision : 1.0 - initial release
// ============================================================================
interface nibble_collector_if
  import nibble_pkg::*;
#(
  parameter int W = LANE_W,
  parameter int N = LANES
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*W-1:0]         out_data;
  logic [$clog2(N+1)-1:0] out_len;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_len
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_len
  );

endinterface
`default_nettype wire

// File: rtl/nibble_collector_word_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : word_out_reg
//  Purpose  : Valid/ready output register. A load always wins (so a load in
//             the same cycle as an out-transfer keeps o_valid high); without
//             a load, an out-transfer clears o_valid. Data/len hold otherwise.
//  Ports    : clk, nrst (sync, active low), i_load, i_data, i_len,
//             i_ready (downstream ready), o_valid, o_data, o_len
//  Revision : 1.0 - initial release
// ============================================================================
module word_out_reg
  import nibble_pkg::*;
#(
  parameter int DW = LANES * LANE_W,
  parameter int LW = LEN_W
) (
  input  wire logic          clk,
  input  wire logic          nrst,
  input  wire logic          i_load,
  input  wire logic [DW-1:0] i_data,
  input  wire logic [LW-1:0] i_len,
  input  wire logic          i_ready,
  output logic               o_valid,
  output logic [DW-1:0]      o_data,
  output logic [LW-1:0]      o_len
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [LW-1:0] r_len;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_len   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_len   <= i_len;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_len   = r_len;

endmodule
`default_nettype wire

// File: rtl/nibble_collector.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_collector
//  Purpose  : Packs N W-bit nibbles into one N*W-bit word (lane 0 in the LSBs)
//             for the combinational sorter. Early in_last pads the remaining
//             lanes with PAD. Two words of buffering: out register + acc.
//  Ports    : clk  - clock
//             nrst - synchronous active-low reset
//             bus  - nibble_collector_if.slave (in_* nibble stream,
//                    out_* packed word stream)
//  Revision : 1.0 - initial release
// ============================================================================
module nibble_collector
  import nibble_pkg::*;
#(
  parameter int           W   = LANE_W,
  parameter int           N   = LANES,
  parameter logic [W-1:0] PAD = {W{1'b1}}
) (
  input wire logic         clk,
  input wire logic         nrst,
  nibble_collector_if.slave bus
);

  localparam int            CW         = (N > 1) ? $clog2(N) : 1;
  localparam int            LW         = $clog2(N + 1);
  localparam logic [CW-1:0] c_CNT_LAST = CW'(N - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [N*W-1:0]   r_acc,   w_acc_nxt;
  logic [LW-1:0]    r_len,   w_len_nxt;
  logic             r_rdy_en;

  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_slot_free;
  logic             w_complete;
  logic [N*W-1:0]   w_word;
  logic [LW-1:0]    w_word_len;
  logic             w_load;
  logic [N*W-1:0]   w_load_data;
  logic [LW-1:0]    w_load_len;
  logic             w_out_valid;

  // r_rdy_en keeps in_ready low through the reset cycle while leaving
  // in_ready a pure function of registered state.
  assign w_in_ready  = r_rdy_en && (r_state == FILL);
  assign w_in_xfer   = bus.in_valid && w_in_ready;
  assign w_slot_free = !w_out_valid || bus.out_ready;
  assign w_complete  = (r_cnt == c_CNT_LAST) || bus.in_last;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;

  // Finished word if the current nibble closes it: stored lanes below cnt,
  // the incoming nibble at cnt, PAD per lane above (stale acc lanes ignored).
  always_comb begin
    w_word = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(r_cnt))
        w_word[k*W +: W] = r_acc[k*W +: W];
      else if (k == int'(r_cnt))
        w_word[k*W +: W] = bus.in_data;
      else
        w_word[k*W +: W] = PAD;
    end
    w_word_len = LW'(r_cnt) + LW'(1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    w_len_nxt   = r_len;
    w_load      = 1'b0;
    w_load_data = w_word;
    w_load_len  = w_word_len;
    case (r_state)
      FILL: begin
        if (w_in_xfer) begin
          if (w_complete) begin
            w_cnt_nxt = '0;
            if (w_slot_free) begin
              w_load = 1'b1;
            end else begin
              w_acc_nxt   = w_word;
              w_len_nxt   = w_word_len;
              w_state_nxt = HOLD;
            end
          end else begin
            w_acc_nxt[r_cnt*W +: W] = bus.in_data;
            w_cnt_nxt               = r_cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = r_acc;
          w_load_len  = r_len;
          w_cnt_nxt   = '0;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= FILL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_len    <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_len    <= w_len_nxt;
      r_rdy_en <= 1'b1;
    end
  end

  word_out_reg #(
    .DW (N*W),
    .LW (LW)
  ) u_word_out_reg (
    .clk     (clk),
    .nrst    (nrst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_len   (w_load_len),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_data  (bus.out_data),
    .o_len   (bus.out_len)
  );

endmodule
`default_nettype wire

// File: tb/tb_nibble_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_collector
//  Purpose  : Scoreboard bench for nibble_collector. Directed nibble vectors
//             push hand-computed words into a queue; a negedge monitor pops
//             and compares on every out-transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_collector;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  l;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  nibble_collector_if #(.W(4), .N(4)) bus ();

  nibble_collector dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  int   stalls   = 0;
  exp_t exp_q[$];
  int   xfer_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every out-transfer consumes one expected word.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (nrst && bus.out_valid && bus.out_ready) begin
      xfer_cyc.push_back(cyc);
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got %h expected none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.d));
        check("out_len", 32'(bus.out_len), 32'(e.l));
      end
    end
  end

  task automatic expect_word(input logic [15:0] d, input logic [2:0] l);
    exp_q.push_back('{d: d, l: l});
  endtask

  // Called #1 after a posedge; returns #1 after the edge that took the nibble.
  task automatic send(input logic [3:0] d, input logic last);
    int waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 for nibble %0h", d);
    end
    stalls += waits;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    nrst          = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_len", 32'(bus.out_len), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: full word, one-cycle latency
    expect_word(16'h2413, 3'd4);
    send(4'd3, 1'b0);
    send(4'd1, 1'b0);
    send(4'd4, 1'b0);
    send(4'd2, 1'b0);
    check("t1_latency_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // 2: short words; then in_last while idle is ignored, in_last on lane 3
    expect_word(16'hFFF7, 3'd1);
    send(4'd7, 1'b1);
    check("t2_latency_valid", 32'(bus.out_valid), 32'd1);
    expect_word(16'hFF65, 3'd2);
    send(4'd5, 1'b0);
    send(4'd6, 1'b1);
    drain();
    expect_word(16'h4321, 3'd4);
    send(4'd1, 1'b0);
    bus.in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_last = 1'b0;
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    send(4'd4, 1'b1);
    drain();

    // 3: backpressure, two words buffered
    bus.out_ready = 1'b0;
    expect_word(16'h4321, 3'd4);
    expect_word(16'h8765, 3'd4);
    expect_word(16'hCBA9, 3'd4);
    for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
    check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
    check("t3_out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_data", 32'(bus.out_data), 32'h4321);
      check("t3_hold_len", 32'(bus.out_len), 32'd4);
      check("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_in_ready_back", 32'(bus.in_ready), 32'd1);
    check("t3_second_word", 32'(bus.out_data), 32'h8765);
    for (int i = 9; i <= 12; i++) send(4'(i), 1'b0);
    drain();

    // 4: continuous streaming, no bubbles
    stalls = 0;
    xfer_cyc.delete();
    expect_word(16'h3210, 3'd4);
    expect_word(16'hBA98, 3'd4);
    for (int i = 0; i < 4; i++) send(4'(i), 1'b0);
    for (int i = 8; i < 12; i++) send(4'(i), 1'b0);
    drain();
    check("t4_stalls", 32'(stalls), 32'd0);
    check("t4_words", 32'(xfer_cyc.size()), 32'd2);
    if (xfer_cyc.size() == 2)
      check("t4_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd4);

    // 5: reset mid-word discards partial data
    send(4'hD, 1'b0);
    send(4'hE, 1'b0);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_out_data", 32'(bus.out_data), 32'd0);
    check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_after_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_after_out_data", 32'(bus.out_data), 32'd0);
    check("t5_after_in_ready", 32'(bus.in_ready), 32'd1);
    expect_word(16'h6789, 3'd4);
    send(4'd9, 1'b0);
    send(4'd8, 1'b0);
    send(4'd7, 1'b0);
    send(4'd6, 1'b0);
    drain();

    // 6: completion coincides with out-transfer of previous word
    bus.out_ready = 1'b0;
    expect_word(16'h1111, 3'd4);
    expect_word(16'h5432, 3'd4);
    for (int i = 0; i < 4; i++) send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    send(4'd4, 1'b0);
    bus.out_ready = 1'b1;
    send(4'd5, 1'b0);
    check("t6_out_valid", 32'(bus.out_valid), 32'd1);
    check("t6_out_data", 32'(bus.out_data), 32'h5432);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    check("total_words", 32'(n_out), 32'd12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
